fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Shares one framebuffer RAM port between video scanout and two draw requesters, and double-buffers front/back.
// Latency: grant comb at t, memory command registered at t+1, rvalid/rdata at t+2, pixel/pixel_valid at t+3.
// Backpressure: scanout owns every even-x active cycle; requesters hold reqN until gntN, alternating round-robin on ties.
//
// Ports:
//   clk, reset_n                  system clock (2x pixel rate), async active-low reset
//   canDraw, x, y, start_of_frame video timing inputs
//   req/we/addr/wdata{0,1}        draw requester commands; gnt{0,1} combinational accept
//   rvalid{0,1}, rdata            read return (rdata is the raw memory read bus)
//   mem_*                         registered synchronous-RAM command, mem_rdata one cycle later
//   pixel, pixel_valid            scanout pixel stream
//   swap_req, swap_done, front    buffer swap request / completion pulse / current scanout buffer
module fb_arbiter #(
    parameter int DW    = 8,
    parameter int H_ACT = 640
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          canDraw,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          start_of_frame,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [18:0]   addr0,
    input  logic [18:0]   addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [19:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pixel,
    output logic          pixel_valid,
    input  logic          swap_req,
    output logic          swap_done,
    output logic          front
);

    // State flops
    logic          rr_q, rr_d;              // 1: requester 1 wins the next tie
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [19:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          rd0_s1_q, rd0_s1_d;      // read of requester 0 issued, data due next cycle
    logic          rd1_s1_q, rd1_s1_d;
    logic          scan_s1_q, scan_s1_d;    // scanout fetch issued
    logic          scan_s2_q, scan_s2_d;    // scanout data on mem_rdata this cycle
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] pixel_q, pixel_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          front_q, front_d;
    logic          pending_q, pending_d;
    logic          swap_done_q, swap_done_d;

    logic          scan_slot;
    logic          swap_fire;
    logic [18:0]   y_ext;
    logic [18:0]   line_base;
    logic [18:0]   pix_idx;

    // Each pixel lasts two clocks; the even half belongs to scanout.
    assign scan_slot = canDraw & ~x[0];

    // 640 = 512 + 128, so the line base is two shifts and an add.
    assign y_ext     = {8'd0, y};
    assign line_base = (H_ACT == 640) ? ((y_ext << 9) + (y_ext << 7))
                                      : (y_ext * 19'(H_ACT));
    assign pix_idx   = line_base + {9'd0, x[10:1]};

    // Grant: never during reset or a scan slot; ties go to the requester not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !scan_slot) begin
            if (req0 && (!req1 || !rr_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d        = rr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd0_s1_d    = 1'b0;
        rd1_s1_d    = 1'b0;
        scan_s1_d   = 1'b0;

        if (scan_slot) begin
            mem_en_d   = 1'b1;
            mem_addr_d = {front_q, pix_idx};
            scan_s1_d  = 1'b1;
        end else if (gnt0) begin
            // Draw traffic always targets the back buffer as seen in the grant cycle.
            mem_en_d    = 1'b1;
            mem_we_d    = we0;
            mem_addr_d  = {~front_q, addr0};
            mem_wdata_d = wdata0;
            rd0_s1_d    = ~we0;
            rr_d        = 1'b1;
        end else if (gnt1) begin
            mem_en_d    = 1'b1;
            mem_we_d    = we1;
            mem_addr_d  = {~front_q, addr1};
            mem_wdata_d = wdata1;
            rd1_s1_d    = ~we1;
            rr_d        = 1'b0;
        end

        rvalid0_d     = rd0_s1_q;
        rvalid1_d     = rd1_s1_q;
        scan_s2_d     = scan_s1_q;
        pixel_d       = scan_s2_q ? mem_rdata : pixel_q;
        pixel_valid_d = scan_s2_q;

        // A swap request in the same cycle as frame start takes effect immediately.
        swap_fire   = start_of_frame & (pending_q | swap_req);
        front_d     = front_q ^ swap_fire;
        pending_d   = ~swap_fire & (pending_q | swap_req);
        swap_done_d = swap_fire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q          <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd0_s1_q      <= 1'b0;
            rd1_s1_q      <= 1'b0;
            scan_s1_q     <= 1'b0;
            scan_s2_q     <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            front_q       <= 1'b0;
            pending_q     <= 1'b0;
            swap_done_q   <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd0_s1_q      <= rd0_s1_d;
            rd1_s1_q      <= rd1_s1_d;
            scan_s1_q     <= scan_s1_d;
            scan_s2_q     <= scan_s2_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            front_q       <= front_d;
            pending_q     <= pending_d;
            swap_done_q   <= swap_done_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata       = mem_rdata;
    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign front       = front_q;
    assign swap_done   = swap_done_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a synchronous-read memory model and read/pixel scoreboards.
// Latency: checks command at t+1, rvalid at t+2, pixel_valid at t+3 relative to the grant/scan cycle.
// Backpressure: requesters are held until granted, matching the arbiter's handshake.
module tb_fb_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          canDraw, start_of_frame, swap_req;
    logic [10:0]   x, y;
    logic          req0, req1, we0, we1;
    logic [18:0]   addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [19:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] pixel;
    logic          pixel_valid, swap_done, front;

    always #5 clk = ~clk;

    fb_arbiter #(.DW(DW), .H_ACT(640)) dut (
        .clk(clk), .reset_n(reset_n), .canDraw(canDraw), .x(x), .y(y),
        .start_of_frame(start_of_frame),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pixel(pixel), .pixel_valid(pixel_valid),
        .swap_req(swap_req), .swap_done(swap_done), .front(front)
    );

    // Unwritten locations read back a fixed hash of their address.
    function automatic logic [7:0] pre(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19], 7'h5A};
    endfunction

    logic [DW-1:0] mem [logic [19:0]];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : pre(mem_addr);
        end
    end

    typedef struct packed { logic id; logic [7:0] d; } rd_t;
    rd_t          rd_q[$];
    logic [7:0]   pix_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic         exp_front = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        chk(tag, {31'd0, got}, {31'd0, exp});
    endtask

    // Push the expected scanout pixel if the currently driven cycle is a scan slot.
    task automatic scan_push();
        logic [31:0] idx;
        if (canDraw && !x[0]) begin
            idx = 32'(y) * 32'd640 + 32'(x >> 1);
            pix_q.push_back(pre({exp_front, idx[18:0]}));
        end
    endtask

    // Advance to the next falling edge and retire any returned data against the scoreboards.
    task automatic tick();
        @(negedge clk);
        if (rvalid0 || rvalid1) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                chk1("rd_id", rvalid1, e.id);
                chk("rd_data", 32'(rdata), 32'(e.d));
            end
        end
        if (pixel_valid) begin
            if (pix_q.size() == 0) begin
                chk1("pix_unexpected", pixel_valid, 1'b0);
            end else begin
                logic [7:0] p;
                p = pix_q.pop_front();
                chk("pixel_data", 32'(pixel), 32'(p));
            end
        end
    endtask

    initial begin
        reset_n = 1'b1; canDraw = 0; x = '0; y = '0; start_of_frame = 0; swap_req = 0;
        req0 = 1'b1; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Asynchronous reset, checked before any clock edge
        #2 reset_n = 1'b0;
        #1;
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk1("rst_pixel_valid", pixel_valid, 1'b0);
        chk1("rst_swap_done", swap_done, 1'b0);
        chk1("rst_front", front, 1'b0);
        chk1("rst_gnt0", gnt0, 1'b0);
        req0 = 0;
        tick(); tick();

        // Continuous writes from both requesters during blanking: grants alternate 0,1,0,1
        reset_n = 1'b1;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        for (int i = 0; i < 4; i++) begin
            addr0 = 19'(16 + i); addr1 = 19'(32 + i);
            wdata0 = 8'(8'h10 + i); wdata1 = 8'(8'h20 + i);
            #1;
            chk1("alt_gnt0", gnt0, (i % 2) == 0);
            chk1("alt_gnt1", gnt1, (i % 2) == 1);
            tick();
            chk1("alt_mem_en", mem_en, 1'b1);
            chk1("alt_mem_we", mem_we, 1'b1);
            chk("alt_mem_addr", 32'(mem_addr), ((i % 2) == 0) ? 32'h80000 + 32'(16 + i) : 32'h80000 + 32'(32 + i));
            chk("alt_mem_wdata", 32'(mem_wdata), ((i % 2) == 0) ? 32'h10 + 32'(i) : 32'h20 + 32'(i));
        end
        req0 = 0; req1 = 0;
        tick();
        chk1("idle_mem_en", mem_en, 1'b0);
        chk1("idle_mem_we", mem_we, 1'b0);
        chk("idle_addr_held", 32'(mem_addr), 32'h80023);
        chk("idle_wdata_held", 32'(mem_wdata), 32'h23);

        // Scan slot at y=2, x=10 with a pending write from requester 0
        canDraw = 1; y = 11'd2; x = 11'd10;
        req0 = 1; we0 = 1; addr0 = 19'h123; wdata0 = 8'hAB;
        scan_push();
        #1;
        chk1("scan_gnt0", gnt0, 1'b0);
        chk1("scan_gnt1", gnt1, 1'b0);
        tick();
        chk1("scan_mem_en", mem_en, 1'b1);
        chk1("scan_mem_we", mem_we, 1'b0);
        chk("scan_mem_addr", 32'(mem_addr), 32'h00505);
        x = 11'd11; scan_push();
        #1;
        chk1("free_gnt0", gnt0, 1'b1);
        tick();
        chk("wr_mem_addr", 32'(mem_addr), 32'h80123);
        chk1("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hAB);
        chk("scan_rdata", 32'(rdata), 32'(pre(20'h00505)));
        chk1("pv_before", pixel_valid, 1'b0);
        req0 = 0; x = 11'd12; scan_push();
        tick();
        chk1("pv_pulse", pixel_valid, 1'b1);
        chk("scan2_mem_addr", 32'(mem_addr), 32'h00506);
        canDraw = 0;
        tick();
        chk1("pv_gap", pixel_valid, 1'b0);
        chk("pixel_hold", 32'(pixel), 32'(pre(20'h00505)));
        tick();
        chk1("pv_pulse2", pixel_valid, 1'b1);
        tick();
        chk1("pv_gap2", pixel_valid, 1'b0);

        // Held write request during active video is granted only on odd-x cycles
        canDraw = 1; req0 = 1; we0 = 1; addr0 = 19'h200; wdata0 = 8'h33;
        for (int i = 0; i < 4; i++) begin
            x = 11'(20 + i);
            scan_push();
            #1;
            chk1("act_gnt0", gnt0, (i % 2) == 1);
            chk1("act_gnt1", gnt1, 1'b0);
            tick();
        end
        req0 = 0; canDraw = 0;
        tick(); tick(); tick();

        // Reads: tie goes to requester 1 (0 was served last), then requester 0 back-to-back
        req0 = 1; we0 = 0; addr0 = 19'h123;
        req1 = 1; we1 = 0; addr1 = 19'd5;
        #1;
        chk1("rd_tie_gnt1", gnt1, 1'b1);
        chk1("rd_tie_gnt0", gnt0, 1'b0);
        rd_q.push_back({1'b1, pre(20'h80005)});
        tick();
        chk1("rd1_mem_en", mem_en, 1'b1);
        chk1("rd1_mem_we", mem_we, 1'b0);
        chk("rd1_mem_addr", 32'(mem_addr), 32'h80005);
        chk1("rd1_early", rvalid1, 1'b0);
        req1 = 0;
        #1;
        chk1("rd0_gnt0", gnt0, 1'b1);
        rd_q.push_back({1'b0, 8'hAB});
        tick();
        chk1("rd1_valid", rvalid1, 1'b1);
        chk("rd0_mem_addr", 32'(mem_addr), 32'h80123);
        req0 = 0;
        tick();
        chk1("rd1_once", rvalid1, 1'b0);
        chk1("rd0_valid", rvalid0, 1'b1);
        tick();
        chk1("rd0_once", rvalid0, 1'b0);

        // Swap: request mid-frame, repeat while pending, takes effect at frame start only once
        swap_req = 1; tick(); swap_req = 0;
        chk1("swap_wait_front", front, 1'b0);
        chk1("swap_wait_done", swap_done, 1'b0);
        swap_req = 1; tick(); swap_req = 0;
        tick();
        chk1("swap_still_front", front, 1'b0);
        start_of_frame = 1; tick(); start_of_frame = 0;
        exp_front = 1'b1;
        chk1("swap_front", front, 1'b1);
        chk1("swap_done_pulse", swap_done, 1'b1);
        tick();
        chk1("swap_done_end", swap_done, 1'b0);
        start_of_frame = 1; tick(); start_of_frame = 0;
        chk1("sof_nop_front", front, 1'b1);
        chk1("sof_nop_done", swap_done, 1'b0);
        req0 = 1; we0 = 1; addr0 = 19'h42; wdata0 = 8'h5C;
        #1;
        chk1("post_swap_gnt0", gnt0, 1'b1);
        tick();
        req0 = 0;
        chk("post_swap_addr", 32'(mem_addr), 32'h00042);
        canDraw = 1; x = '0; y = '0; scan_push();
        tick();
        chk("post_swap_scan", 32'(mem_addr), 32'h80000);
        canDraw = 0;
        tick(); tick(); tick();
        swap_req = 1; start_of_frame = 1; tick(); swap_req = 0; start_of_frame = 0;
        exp_front = 1'b0;
        chk1("same_cycle_front", front, 1'b0);
        chk1("same_cycle_done", swap_done, 1'b1);

        // Reset one cycle after a granted read
        swap_req = 1; start_of_frame = 1; tick(); swap_req = 0; start_of_frame = 0;
        exp_front = 1'b1;
        req0 = 1; we0 = 0; addr0 = 19'd7;
        #1;
        chk1("pre_rst_gnt0", gnt0, 1'b1);
        tick();
        req0 = 0; reset_n = 1'b0;
        #1;
        chk1("mid_rst_mem_en", mem_en, 1'b0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk1("mid_rst_front", front, 1'b0);
        chk("mid_rst_pixel", 32'(pixel), 32'd0);
        chk1("mid_rst_rvalid0", rvalid0, 1'b0);
        req0 = 1;
        #1;
        chk1("mid_rst_gnt0", gnt0, 1'b0);
        req0 = 0;
        tick();
        reset_n = 1'b1;
        exp_front = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("post_rst_no_rvalid", rvalid0, 1'b0);
        end
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        #1;
        chk1("post_rst_tie_gnt0", gnt0, 1'b1);
        chk1("post_rst_tie_gnt1", gnt1, 1'b0);
        tick();
        req0 = 0; req1 = 0;
        tick(); tick();

        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        chk("pix_q_empty", 32'(pix_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
